// File: rtl/flash_region_loader_pkg.sv
// flash_region_loader_pkg
//   Shared types and constants for the boot-time flash-to-SD-RAM copier.
//   - load_region_t : one table entry {flash_addr, ram_addr, size}, sizes in bytes
//   - LOAD_REGIONS  : number of entries in the default load table
//   - LR_*          : index of each region inside the table / region_en mask
//   - LOAD_TABLE    : default table built from the flash/RAM layout constants
//   - region_ok()   : true when an entry's size and RAM address are both even
package flash_region_loader_pkg;

  typedef struct packed {
    logic [23:0] flash_addr;
    logic [23:0] ram_addr;
    logic [23:0] size;
  } load_region_t;

  localparam int LOAD_REGIONS = 4;

  typedef load_region_t [LOAD_REGIONS-1:0] load_table_t;

  localparam int LR_NEXTOR  = 0;
  localparam int LR_FM      = 1;
  localparam int LR_PAC     = 2;
  localparam int LR_MEGAROM = 3;

  // Flash image layout and SD-RAM placement of each boot region.
  localparam logic [23:0] NEXTOR_FLASH_ADDR  = 24'h10_0000;
  localparam logic [23:0] NEXTOR_RAM_ADDR    = 24'h00_0000;
  localparam logic [23:0] NEXTOR_SIZE        = 24'h02_0000;
  localparam logic [23:0] FM_FLASH_ADDR      = 24'h12_0000;
  localparam logic [23:0] FM_RAM_ADDR        = 24'h02_0000;
  localparam logic [23:0] FM_SIZE            = 24'h00_4000;
  localparam logic [23:0] PAC_FLASH_ADDR     = 24'h12_4000;
  localparam logic [23:0] PAC_RAM_ADDR       = 24'h02_4000;
  localparam logic [23:0] PAC_SIZE           = 24'h00_2000;
  localparam logic [23:0] MEGAROM_FLASH_ADDR = 24'h20_0000;
  localparam logic [23:0] MEGAROM_RAM_ADDR   = 24'h10_0000;
  localparam logic [23:0] MEGAROM_SIZE       = 24'h10_0000;

  function automatic load_table_t build_load_table();
    load_table_t t;
    t[LR_NEXTOR]  = '{flash_addr: NEXTOR_FLASH_ADDR,  ram_addr: NEXTOR_RAM_ADDR,  size: NEXTOR_SIZE};
    t[LR_FM]      = '{flash_addr: FM_FLASH_ADDR,      ram_addr: FM_RAM_ADDR,      size: FM_SIZE};
    t[LR_PAC]     = '{flash_addr: PAC_FLASH_ADDR,     ram_addr: PAC_RAM_ADDR,     size: PAC_SIZE};
    t[LR_MEGAROM] = '{flash_addr: MEGAROM_FLASH_ADDR, ram_addr: MEGAROM_RAM_ADDR, size: MEGAROM_SIZE};
    return t;
  endfunction

  localparam load_table_t LOAD_TABLE = build_load_table();

  // Words are written whole, so an odd size or odd RAM address cannot be copied.
  function automatic logic region_ok(input load_region_t r);
    return !r.size[0] && !r.ram_addr[0];
  endfunction

endpackage

// File: rtl/flash_region_loader.sv
// flash_region_loader
//   Copies each enabled, non-empty region of TABLE from SPI flash into SD-RAM,
//   one little-endian 16-bit word at a time, after a one-cycle start pulse.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   start, region_en       start pulse and per-region enable (sampled at start)
//   busy, done, cur_region status; done is sticky until the next accepted start
//   fl_cmd_*               flash read command (valid/ready)
//   fl_data_*              flash byte stream (valid/ready)
//   ram_req/ack/addr/wdata SD-RAM word write, req held until a one-cycle ack
//   dbg_state              current FSM state encoding
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high; a source keeps valid and its payload stable until that edge.
module flash_region_loader
  import flash_region_loader_pkg::*;
#(
  parameter int REGIONS = LOAD_REGIONS,
  parameter load_region_t [REGIONS-1:0] TABLE = LOAD_TABLE
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [REGIONS-1:0] region_en,
  output logic               busy,
  output logic               done,
  output logic [2:0]         cur_region,
  output logic               fl_cmd_valid,
  input  logic               fl_cmd_ready,
  output logic [23:0]        fl_cmd_addr,
  output logic [23:0]        fl_cmd_len,
  input  logic               fl_data_valid,
  input  logic [7:0]         fl_data,
  output logic               fl_data_ready,
  output logic               ram_req,
  input  logic               ram_ack,
  output logic [23:0]        ram_addr,
  output logic [15:0]        ram_wdata,
  output logic [2:0]         dbg_state
);

  localparam int IDX_W = 4;

  // Table sanity is checked when the design is elaborated.
  if (REGIONS < 1 || REGIONS > 8) begin : g_bad_regions
    $error("flash_region_loader: REGIONS must be 1..8");
  end
  for (genvar g = 0; g < REGIONS; g++) begin : g_table_check
    if (!region_ok(TABLE[g])) begin : g_bad_entry
      $error("flash_region_loader: odd size or ram_addr in table entry");
    end
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_CMD    = 3'd2,
    S_LO     = 3'd3,
    S_HI     = 3'd4,
    S_WRITE  = 3'd5,
    S_NEXT   = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [REGIONS-1:0] mask_q, mask_d;
  logic [23:0]        rem_q, rem_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [2:0]         cur_region_q, cur_region_d;
  logic               fl_cmd_valid_q, fl_cmd_valid_d;
  logic [23:0]        fl_cmd_addr_q, fl_cmd_addr_d;
  logic [23:0]        fl_cmd_len_q, fl_cmd_len_d;
  logic               fl_data_ready_q, fl_data_ready_d;
  logic               ram_req_q, ram_req_d;
  logic [23:0]        ram_addr_q, ram_addr_d;
  logic [15:0]        ram_wdata_q, ram_wdata_d;

  load_region_t       sel;
  logic               sel_en;

  // Entry and enable bit for the current index; idx==REGIONS selects nothing.
  always_comb begin
    sel    = '0;
    sel_en = 1'b0;
    for (int g = 0; g < REGIONS; g++) begin
      if (idx_q == IDX_W'(g)) begin
        sel    = TABLE[g];
        sel_en = mask_q[g];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    mask_d        = mask_q;
    rem_d         = rem_q;
    done_d        = done_q;
    fl_cmd_addr_d = fl_cmd_addr_q;
    fl_cmd_len_d  = fl_cmd_len_q;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d  = region_en;
          done_d  = 1'b0;
          idx_d   = '0;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (idx_q == IDX_W'(REGIONS)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (!sel_en || sel.size == 24'd0) begin
          state_d = S_NEXT;
        end else begin
          fl_cmd_addr_d = sel.flash_addr;
          fl_cmd_len_d  = sel.size;
          ram_addr_d    = sel.ram_addr;
          rem_d         = sel.size;
          state_d       = S_CMD;
        end
      end
      S_CMD: begin
        if (fl_cmd_ready) state_d = S_LO;
      end
      S_LO: begin
        if (fl_data_valid) begin
          ram_wdata_d[7:0] = fl_data;
          state_d          = S_HI;
        end
      end
      S_HI: begin
        if (fl_data_valid) begin
          ram_wdata_d[15:8] = fl_data;
          state_d           = S_WRITE;
        end
      end
      S_WRITE: begin
        if (ram_ack) begin
          ram_addr_d = ram_addr_q + 24'd2;
          rem_d      = rem_q - 24'd2;
          state_d    = (rem_q == 24'd2) ? S_NEXT : S_LO;
        end
      end
      S_NEXT: begin
        idx_d   = idx_q + 1'b1;
        state_d = S_SELECT;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so that every output is a flop
    // that lines up with the state it belongs to.
    busy_d          = (state_d != S_IDLE) && (state_d != S_DONE);
    fl_cmd_valid_d  = (state_d == S_CMD);
    fl_data_ready_d = (state_d == S_LO) || (state_d == S_HI);
    ram_req_d       = (state_d == S_WRITE);
    cur_region_d    = idx_d[2:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      mask_q          <= '0;
      rem_q           <= '0;
      done_q          <= 1'b0;
      busy_q          <= 1'b0;
      cur_region_q    <= '0;
      fl_cmd_valid_q  <= 1'b0;
      fl_cmd_addr_q   <= '0;
      fl_cmd_len_q    <= '0;
      fl_data_ready_q <= 1'b0;
      ram_req_q       <= 1'b0;
      ram_addr_q      <= '0;
      ram_wdata_q     <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      mask_q          <= mask_d;
      rem_q           <= rem_d;
      done_q          <= done_d;
      busy_q          <= busy_d;
      cur_region_q    <= cur_region_d;
      fl_cmd_valid_q  <= fl_cmd_valid_d;
      fl_cmd_addr_q   <= fl_cmd_addr_d;
      fl_cmd_len_q    <= fl_cmd_len_d;
      fl_data_ready_q <= fl_data_ready_d;
      ram_req_q       <= ram_req_d;
      ram_addr_q      <= ram_addr_d;
      ram_wdata_q     <= ram_wdata_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign cur_region    = cur_region_q;
  assign fl_cmd_valid  = fl_cmd_valid_q;
  assign fl_cmd_addr   = fl_cmd_addr_q;
  assign fl_cmd_len    = fl_cmd_len_q;
  assign fl_data_ready = fl_data_ready_q;
  assign ram_req       = ram_req_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_flash_region_loader.sv
module tb_flash_region_loader;
  import flash_region_loader_pkg::*;

  // Bench table: r0 4 bytes, r1 2 bytes, r2 empty, r3 2 bytes.
  localparam load_region_t TB_R0 = '{flash_addr: 24'h00_1000, ram_addr: 24'h10_0000, size: 24'd4};
  localparam load_region_t TB_R1 = '{flash_addr: 24'h00_2000, ram_addr: 24'h20_0000, size: 24'd2};
  localparam load_region_t TB_R2 = '{flash_addr: 24'h00_3000, ram_addr: 24'h30_0000, size: 24'd0};
  localparam load_region_t TB_R3 = '{flash_addr: 24'h00_4000, ram_addr: 24'h40_0000, size: 24'd2};
  localparam load_region_t [3:0] TB_TABLE = {TB_R3, TB_R2, TB_R1, TB_R0};

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [3:0]  region_en;
  logic        busy;
  logic        done;
  logic [2:0]  cur_region;
  logic        fl_cmd_valid;
  logic        fl_cmd_ready;
  logic [23:0] fl_cmd_addr;
  logic [23:0] fl_cmd_len;
  logic        fl_data_valid;
  logic [7:0]  fl_data;
  logic        fl_data_ready;
  logic        ram_req;
  logic        ram_ack;
  logic [23:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [2:0]  dbg_state;

  flash_region_loader #(.REGIONS(4), .TABLE(TB_TABLE)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .region_en(region_en),
    .busy(busy), .done(done), .cur_region(cur_region),
    .fl_cmd_valid(fl_cmd_valid), .fl_cmd_ready(fl_cmd_ready),
    .fl_cmd_addr(fl_cmd_addr), .fl_cmd_len(fl_cmd_len),
    .fl_data_valid(fl_data_valid), .fl_data(fl_data), .fl_data_ready(fl_data_ready),
    .ram_req(ram_req), .ram_ack(ram_ack), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int ack_delay = 0;
  logic [50:0] cmd_exp_q[$];   // {cur_region, flash addr, len}
  logic [39:0] ram_exp_q[$];   // {ram addr, word}

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  task automatic exp_cmd(input logic [2:0] idx, input load_region_t r);
    cmd_exp_q.push_back({idx, r.flash_addr, r.size});
  endtask

  task automatic exp_ram(input logic [23:0] a, input logic [15:0] w);
    ram_exp_q.push_back({a, w});
  endtask

  // Hand-written flash contents at the bench table addresses.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h00_1000: return 8'h01;
      24'h00_1001: return 8'h02;
      24'h00_1002: return 8'h03;
      24'h00_1003: return 8'h04;
      24'h00_2000: return 8'hAA;
      24'h00_2001: return 8'hBB;
      24'h00_4000: return 8'h5A;
      24'h00_4001: return 8'h5B;
      default:     return 8'hEE;
    endcase
  endfunction

  // ---------------- flash reader model ----------------
  initial begin : flash_model
    logic [23:0] s_addr;
    int          s_left;
    bit          data_hs;
    fl_cmd_ready  = 1'b0;
    fl_data_valid = 1'b0;
    fl_data       = 8'h00;
    s_addr  = '0;
    s_left  = 0;
    data_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        fl_cmd_ready  = 1'b0;
        fl_data_valid = 1'b0;
        s_left        = 0;
        data_hs       = 1'b0;
      end else begin
        if (data_hs) begin
          s_addr = s_addr + 24'd1;
          s_left = s_left - 1;
        end
        if (fl_cmd_ready) begin
          fl_cmd_ready = 1'b0;
        end else if (fl_cmd_valid) begin
          fl_cmd_ready = 1'b1;
          s_addr = fl_cmd_addr;
          s_left = int'(fl_cmd_len);
        end
        fl_data_valid = (s_left != 0) && !fl_cmd_ready;
        fl_data       = flash_byte(s_addr);
        data_hs       = fl_data_valid && fl_data_ready;
      end
    end
  end

  // ---------------- SD-RAM arbiter model ----------------
  initial begin : ram_model
    int wait_cnt;
    ram_ack  = 1'b0;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (ram_ack || !reset_n) begin
        ram_ack  = 1'b0;
        wait_cnt = 0;
      end else if (ram_req) begin
        if (wait_cnt >= ack_delay) ram_ack = 1'b1;
        else wait_cnt++;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [50:0] got_c, e_c;
    logic [39:0] got_r, e_r;
    logic [23:0] held_addr;
    logic [15:0] held_wdata;
    bit          req_prev;
    req_prev   = 1'b0;
    held_addr  = '0;
    held_wdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (reset_n && fl_cmd_valid && fl_cmd_ready) begin
        got_c = {cur_region, fl_cmd_addr, fl_cmd_len};
        if (cmd_exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL cmd_unexpected got=%0h exp=none", got_c);
        end else begin
          e_c = cmd_exp_q.pop_front();
          check("cmd", 128'(got_c), 128'(e_c));
        end
      end
      if (reset_n && ram_req && ram_ack) begin
        got_r = {ram_addr, ram_wdata};
        if (ram_exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL ram_unexpected got=%0h exp=none", got_r);
        end else begin
          e_r = ram_exp_q.pop_front();
          check("ram_write", 128'(got_r), 128'(e_r));
        end
      end
      if (ram_req) begin
        if (req_prev) begin
          check("hold_addr", 128'(ram_addr), 128'(held_addr));
          check("hold_wdata", 128'(ram_wdata), 128'(held_wdata));
          check("hold_fl_ready", 128'(fl_data_ready), 128'(0));
        end
        held_addr  = ram_addr;
        held_wdata = ram_wdata;
      end
      req_prev = ram_req;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [3:0] en);
    @(negedge clk);
    region_en = en;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic run_pass(input string name, input logic [3:0] en, input int exp_first, input bit poke);
    int cyc;
    pulse_start(en);
    check({name, "_busy_rise"}, 128'(busy), 128'(1));
    check({name, "_done_clr"}, 128'(done), 128'(0));
    cyc = 1;
    while (!fl_cmd_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_first_cmd_cycles"}, 128'(cyc), 128'(exp_first));
    if (poke) begin
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL %s_done_timeout got=0 exp=1", name);
    end else begin
      check({name, "_busy_at_done"}, 128'(busy), 128'(0));
    end
    repeat (10) @(negedge clk);
    check({name, "_done_sticky"}, 128'(done), 128'(1));
    check({name, "_idle_after"}, 128'(busy), 128'(0));
    check({name, "_cmd_q_empty"}, 128'(cmd_exp_q.size()), 128'(0));
    check({name, "_ram_q_empty"}, 128'(ram_exp_q.size()), 128'(0));
  endtask

  function automatic logic [127:0] all_outputs();
    return 128'({busy, done, cur_region, fl_cmd_valid, fl_cmd_addr, fl_cmd_len,
                 fl_data_ready, ram_req, ram_addr, ram_wdata, dbg_state});
  endfunction

  // ---------------- main sequence ----------------
  initial begin : main
    int cyc;
    reset_n   = 1'b0;
    start     = 1'b0;
    region_en = 4'b0000;
    repeat (3) @(negedge clk);
    check("reset_outputs_zero", all_outputs(), 128'(0));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", all_outputs(), 128'(0));

    // Two regions (4 and 2 bytes), best-case ack.
    exp_cmd(3'd0, TB_R0);
    exp_cmd(3'd1, TB_R1);
    exp_ram(24'h10_0000, 16'h0201);
    exp_ram(24'h10_0002, 16'h0403);
    exp_ram(24'h20_0000, 16'hBBAA);
    run_pass("two_regions", 4'b0011, 2, 1'b0);

    // Only regions 1 and 3; region 0 skip adds 2 cycles before the first command.
    exp_cmd(3'd1, TB_R1);
    exp_cmd(3'd3, TB_R3);
    exp_ram(24'h20_0000, 16'hBBAA);
    exp_ram(24'h40_0000, 16'h5B5A);
    run_pass("en_1010", 4'b1010, 4, 1'b0);

    // All enabled: the empty region 2 gets no command.
    exp_cmd(3'd0, TB_R0);
    exp_cmd(3'd1, TB_R1);
    exp_cmd(3'd3, TB_R3);
    exp_ram(24'h10_0000, 16'h0201);
    exp_ram(24'h10_0002, 16'h0403);
    exp_ram(24'h20_0000, 16'hBBAA);
    exp_ram(24'h40_0000, 16'h5B5A);
    run_pass("zero_size", 4'b1111, 2, 1'b0);

    // Slow ack plus a second start while busy: exactly one pass.
    ack_delay = 5;
    exp_cmd(3'd1, TB_R1);
    exp_ram(24'h20_0000, 16'hBBAA);
    run_pass("slow_ack_restart", 4'b0010, 4, 1'b1);
    ack_delay = 0;

    // Reset while the high byte of region 0 is pending.
    exp_cmd(3'd0, TB_R0);
    pulse_start(4'b0001);
    cyc = 0;
    while (dbg_state != 3'd4 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_hi", 128'(dbg_state), 128'(4));
    reset_n = 1'b0;
    #1;
    check("async_reset_zero", all_outputs(), 128'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", all_outputs(), 128'(0));
    check("abort_cmd_q_empty", 128'(cmd_exp_q.size()), 128'(0));
    exp_cmd(3'd0, TB_R0);
    exp_ram(24'h10_0000, 16'h0201);
    exp_ram(24'h10_0002, 16'h0403);
    run_pass("after_reset", 4'b0001, 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
